// File: rtl/iram_init_pkg.sv
// rtl/iram_init_pkg.sv - shared state and error-code definitions for the IRAM boot loader
package iram_init_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        FAIL
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CHKSUM  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/iram_init_watchdog.sv
// rtl/iram_init_watchdog.sv - idle-cycle counter; expired flags the LIMIT-th consecutive enabled cycle
module iram_init_watchdog #(
    parameter int LIMIT = 65535
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    // LIMIT of zero disables expiry entirely
    assign expired = (LIMIT != 0) && en && (count == CW'(LIMIT - 1));

    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/iram_init_sequencer.sv
// rtl/iram_init_sequencer.sv - streams a boot image into the instruction RAM init port and verifies its checksum
module iram_init_sequencer
    import iram_init_pkg::*;
#(
    parameter int INITWIDTH      = 11,
    parameter int INITDATAWIDTH  = 9,
    parameter int TOTAL_WORDS    = 512,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic [INITDATAWIDTH-1:0] SRC_DATA,
    input  logic                     SRC_VALID,
    output logic                     SRC_READY,
    output logic [INITWIDTH-1:0]     INITADDR,
    output logic [INITDATAWIDTH-1:0] INITDATA,
    output logic                     INITDATVAL,
    output logic                     INITDONE,
    output logic                     BUSY,
    output logic                     ERROR,
    output logic [1:0]               ERR_CODE
);

    localparam logic [INITWIDTH:0] LAST_WORD = (INITWIDTH + 1)'(TOTAL_WORDS - 1);

    state_t                   state, state_nxt;
    logic [INITWIDTH:0]       word_cnt;
    logic [INITDATAWIDTH-1:0] acc;
    logic                     active, hs, expired, start_now;

    assign active    = (state == LOAD) || (state == CHECK);
    assign SRC_READY = active;
    assign hs        = SRC_VALID && active;
    assign start_now = START && ((state == IDLE) || (state == FAIL));

    iram_init_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .CLK     (CLK),
        .RESET   (RESET),
        .clr     (hs || !active),
        .en      (active && !hs),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = LOAD;
            LOAD: begin
                if (hs && (word_cnt == LAST_WORD)) state_nxt = CHECK;
                else if (expired)                  state_nxt = FAIL;
            end
            CHECK: begin
                if (hs)           state_nxt = (SRC_DATA == acc) ? DONE : FAIL;
                else if (expired) state_nxt = FAIL;
            end
            DONE:    state_nxt = DONE;
            FAIL:    if (START) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            word_cnt   <= '0;
            acc        <= '0;
            INITADDR   <= '0;
            INITDATA   <= '0;
            INITDATVAL <= 1'b0;
            INITDONE   <= 1'b0;
            BUSY       <= 1'b0;
            ERROR      <= 1'b0;
            ERR_CODE   <= ERR_NONE;
        end else begin
            state      <= state_nxt;
            INITADDR   <= '0;
            INITDATA   <= '0;
            INITDATVAL <= 1'b0;
            // Trails the DONE state by a cycle so the last strobe never overlaps it
            INITDONE   <= (state == DONE);
            if (start_now) begin
                word_cnt <= '0;
                acc      <= '0;
                BUSY     <= 1'b1;
                ERROR    <= 1'b0;
                ERR_CODE <= ERR_NONE;
            end
            if (state == LOAD && hs) begin
                INITDATVAL <= 1'b1;
                INITADDR   <= word_cnt[INITWIDTH-1:0];
                INITDATA   <= SRC_DATA;
                acc        <= acc + SRC_DATA;
                word_cnt   <= word_cnt + 1'b1;
            end
            if (state_nxt == FAIL && state != FAIL) begin
                BUSY     <= 1'b0;
                ERROR    <= 1'b1;
                ERR_CODE <= (state == CHECK && hs) ? ERR_CHKSUM : ERR_TIMEOUT;
            end
            if (state_nxt == DONE && state == CHECK) begin
                BUSY <= 1'b0;
            end
        end
    end

endmodule
